// File: rtl/spi_exe_pkg.sv
// Shared types and constants for the SPI front end of the exe_unit_rtl ALU.
package spi_exe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    LOAD_OP,
    EXEC,
    SHIFT_OUT,
    WAIT_CS
  } state_t;

  // Flag bit positions in the ALU flag word, sent MSB first as BF,NF,OF,SF.
  // BF: carry (add) / borrow (sub) / bit shifted out (shifts)
  // NF: null result (all zero)
  // OF: signed overflow (add/sub only)
  // SF: sign of the result
  localparam int SF = 0;
  localparam int OF = 1;
  localparam int NF = 2;
  localparam int BF = 3;

  localparam int ALU_FLAG_W = 4;

  // Opcodes understood by exe_unit_rtl; unlisted codes produce a zero result.
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;

endpackage

// File: rtl/exe_unit_rtl.sv
// Combinational ALU: result and {BF,NF,OF,SF} flags from two operands and an opcode.
module exe_unit_rtl
  import spi_exe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OPER_W = 4
) (
  input  logic [DATA_W-1:0]     i_argA,
  input  logic [DATA_W-1:0]     i_argB,
  input  logic [OPER_W-1:0]     i_oper,
  output logic [DATA_W-1:0]     o_result,
  output logic [ALU_FLAG_W-1:0] o_flags
);

  logic [DATA_W:0] w_wide;
  logic [3:0]      w_op;
  logic            w_carry;
  logic            w_ovf;

  assign w_op     = 4'(i_oper);
  assign o_result = w_wide[DATA_W-1:0];

  // Operation select; carry/overflow only meaningful for arithmetic and shifts
  always_comb begin
    w_wide  = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_wide  = {1'b0, i_argA} + {1'b0, i_argB};
        w_carry = w_wide[DATA_W];
        w_ovf   = (i_argA[DATA_W-1] == i_argB[DATA_W-1]) &&
                  (w_wide[DATA_W-1] != i_argA[DATA_W-1]);
      end
      OP_SUB: begin
        w_wide  = {1'b0, i_argA} - {1'b0, i_argB};
        w_carry = w_wide[DATA_W];
        w_ovf   = (i_argA[DATA_W-1] != i_argB[DATA_W-1]) &&
                  (w_wide[DATA_W-1] != i_argA[DATA_W-1]);
      end
      OP_AND: w_wide = {1'b0, i_argA & i_argB};
      OP_OR:  w_wide = {1'b0, i_argA | i_argB};
      OP_XOR: w_wide = {1'b0, i_argA ^ i_argB};
      OP_NOT: w_wide = {1'b0, ~i_argA};
      OP_SHL: begin
        w_wide  = {i_argA, 1'b0};
        w_carry = i_argA[DATA_W-1];
      end
      OP_SHR: begin
        w_wide  = {2'b00, i_argA[DATA_W-1:1]};
        w_carry = i_argA[0];
      end
      default: w_wide = '0;
    endcase
  end

  // Pack the flag word from the selected operation's side results
  always_comb begin
    o_flags     = '0;
    o_flags[BF] = w_carry;
    o_flags[NF] = ~|o_result;
    o_flags[OF] = w_ovf;
    o_flags[SF] = o_result[DATA_W-1];
  end

endmodule

// File: rtl/spi_field_counter.sv
// Loadable down-counter with zero flag, shared by every phase of the SPI frame.
module spi_field_counter #(
  parameter int CNT_W = 4
) (
  input  logic             i_sclk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [CNT_W-1:0] i_value,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

  // Load wins over decrement; the count parks at zero rather than wrapping
  always_ff @(posedge i_sclk or negedge i_rst) begin
    if (!i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/spi_exe_unit_n.sv
// SPI mode-0 slave: shifts in argA, argB and an opcode field, runs exe_unit_rtl,
// and shifts {result, flags} back out MSB first.
module spi_exe_unit_n
  import spi_exe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OPER_W = 4,
  parameter int FLAG_W = 4,
  parameter int BURST  = 0
) (
  input  logic i_sclk,
  input  logic i_rst,
  input  logic i_cs,
  input  logic i_mosi,
  output logic o_miso,
  output logic o_busy,
  output logic o_done,
  output logic o_frame_err
);

  localparam int RESP_W = DATA_W + FLAG_W;
  localparam int CNT_W  = $clog2(RESP_W + 1);
  localparam logic [CNT_W-1:0] FIELD_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] RESP_LAST  = CNT_W'(RESP_W - 1);

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_shIn;
  logic [DATA_W-1:0]   r_argA;
  logic [DATA_W-1:0]   r_argB;
  logic [OPER_W-1:0]   r_oper;
  logic [RESP_W-1:0]   r_shOut;
  logic                r_miso;
  logic                r_done;
  logic                r_err;
  logic [DATA_W-1:0]   w_field;
  logic [DATA_W-1:0]   w_result;
  logic [FLAG_W-1:0]   w_flags;
  logic                w_cntLoad;
  logic                w_cntDec;
  logic                w_cntZero;
  logic                w_lastBit;
  logic [CNT_W-1:0]    w_cnt;
  logic [CNT_W-1:0]    w_cntValue;

  assign w_field     = {r_shIn[DATA_W-2:0], i_mosi};
  assign w_lastBit   = (w_cnt == CNT_W'(1));
  assign o_miso      = r_miso;
  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;
  assign o_frame_err = r_err;

  spi_field_counter #(.CNT_W(CNT_W)) u_counter (
    .i_sclk  (i_sclk),
    .i_rst   (i_rst),
    .i_load  (w_cntLoad),
    .i_dec   (w_cntDec),
    .i_value (w_cntValue),
    .o_count (w_cnt),
    .o_zero  (w_cntZero)
  );

  exe_unit_rtl #(.DATA_W(DATA_W), .OPER_W(OPER_W)) u_alu (
    .i_argA   (r_argA),
    .i_argB   (r_argB),
    .i_oper   (r_oper),
    .o_result (w_result),
    .o_flags  (w_flags)
  );

  // State register
  always_ff @(posedge i_sclk or negedge i_rst) begin
    if (!i_rst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state and counter control; CS high aborts every active phase first
  always_comb begin
    w_next     = r_state;
    w_cntLoad  = 1'b0;
    w_cntDec   = 1'b0;
    w_cntValue = FIELD_LAST;
    case (r_state)
      IDLE: begin
        if (!i_cs) begin
          w_next    = LOAD_A;
          w_cntLoad = 1'b1;
        end
      end
      LOAD_A, LOAD_B: begin
        if (i_cs) begin
          w_next = IDLE;
        end else if (w_cntZero) begin
          w_next    = (r_state == LOAD_A) ? LOAD_B : LOAD_OP;
          w_cntLoad = 1'b1;
        end else begin
          w_cntDec = 1'b1;
        end
      end
      LOAD_OP: begin
        if (i_cs) begin
          w_next = IDLE;
        end else begin
          w_cntDec = 1'b1;
          if (w_lastBit) w_next = EXEC;
        end
      end
      EXEC: begin
        if (i_cs) begin
          w_next = IDLE;
        end else begin
          w_next     = SHIFT_OUT;
          w_cntLoad  = 1'b1;
          w_cntValue = RESP_LAST;
        end
      end
      SHIFT_OUT: begin
        if (i_cs) begin
          w_next = IDLE;
        end else if (w_cntZero) begin
          w_next = (BURST != 0) ? IDLE : WAIT_CS;
        end else begin
          w_cntDec = 1'b1;
        end
      end
      WAIT_CS: begin
        if (i_cs) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: field capture, response shifter, MISO, done strobe and sticky error
  always_ff @(posedge i_sclk or negedge i_rst) begin
    if (!i_rst) begin
      r_shIn  <= '0;
      r_argA  <= '0;
      r_argB  <= '0;
      r_oper  <= '0;
      r_shOut <= '0;
      r_miso  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_miso <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!i_cs) begin
            r_shIn <= w_field;
            r_err  <= 1'b0;
          end
        end
        LOAD_A: begin
          if (i_cs) begin
            r_err <= 1'b1;
          end else begin
            r_shIn <= w_field;
            if (w_lastBit) r_argA <= w_field;
          end
        end
        LOAD_B: begin
          if (i_cs) begin
            r_err <= 1'b1;
          end else begin
            r_shIn <= w_field;
            if (w_lastBit) r_argB <= w_field;
          end
        end
        LOAD_OP: begin
          if (i_cs) begin
            r_err <= 1'b1;
          end else begin
            r_shIn <= w_field;
            if (w_lastBit) r_oper <= w_field[DATA_W-1 -: OPER_W];
          end
        end
        EXEC: begin
          if (i_cs) begin
            r_err <= 1'b1;
          end else begin
            r_shOut <= {w_result, w_flags};
            r_miso  <= w_result[DATA_W-1];
          end
        end
        SHIFT_OUT: begin
          if (i_cs) begin
            r_err <= 1'b1;
          end else if (w_cntZero) begin
            r_done <= 1'b1;
          end else begin
            r_shOut <= r_shOut << 1;
            r_miso  <= r_shOut[RESP_W-2];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_exe_unit_n.sv
// Bench for spi_exe_unit_n: three instances (8-bit, 8-bit burst, 16-bit) driven
// frame by frame, with expected outputs derived from a frame timeline and an
// arithmetic model of the ALU.
module tb_spi_exe_unit_n;

  localparam int N_DUT = 3;

  logic             clk = 1'b0;
  logic             rstN;
  logic [N_DUT-1:0] cs;
  logic [N_DUT-1:0] mosi;
  logic [N_DUT-1:0] miso;
  logic [N_DUT-1:0] busy;
  logic [N_DUT-1:0] done;
  logic [N_DUT-1:0] ferr;
  logic [N_DUT-1:0] expMiso;
  logic [N_DUT-1:0] expBusy;
  logic [N_DUT-1:0] expDone;
  logic [N_DUT-1:0] expErr;
  logic [N_DUT-1:0] errSt;
  int               total = 0;
  int               bad   = 0;
  bit               checkOn = 1'b0;
  int               widthOf [N_DUT] = '{8, 8, 16};
  bit               burstOf [N_DUT] = '{1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  spi_exe_unit_n #(.DATA_W(8), .OPER_W(4), .FLAG_W(4), .BURST(0)) dut0 (
    .i_sclk(clk), .i_rst(rstN), .i_cs(cs[0]), .i_mosi(mosi[0]),
    .o_miso(miso[0]), .o_busy(busy[0]), .o_done(done[0]), .o_frame_err(ferr[0])
  );

  spi_exe_unit_n #(.DATA_W(8), .OPER_W(4), .FLAG_W(4), .BURST(1)) dut1 (
    .i_sclk(clk), .i_rst(rstN), .i_cs(cs[1]), .i_mosi(mosi[1]),
    .o_miso(miso[1]), .o_busy(busy[1]), .o_done(done[1]), .o_frame_err(ferr[1])
  );

  spi_exe_unit_n #(.DATA_W(16), .OPER_W(4), .FLAG_W(4), .BURST(0)) dut2 (
    .i_sclk(clk), .i_rst(rstN), .i_cs(cs[2]), .i_mosi(mosi[2]),
    .o_miso(miso[2]), .o_busy(busy[2]), .o_done(done[2]), .o_frame_err(ferr[2])
  );

  // ALU reference: response word {result, BF, NF, OF, SF} from integer arithmetic
  function automatic logic [19:0] model(input int w, input int a, input int b, input int op);
    int   m, half, r, s, sa, sb;
    logic bf, of, nf, sf;
    m    = 1 << w;
    half = m / 2;
    bf   = 1'b0;
    of   = 1'b0;
    r    = 0;
    sa   = (a >= half) ? a - m : a;
    sb   = (b >= half) ? b - m : b;
    case (op)
      0: begin
        s  = a + b;
        r  = s % m;
        bf = (s >= m);
        s  = sa + sb;
        of = (s < -half) || (s >= half);
      end
      1: begin
        r  = (a - b + m) % m;
        bf = (a < b);
        s  = sa - sb;
        of = (s < -half) || (s >= half);
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = m - 1 - a;
      6: begin
        r  = (a * 2) % m;
        bf = (a >= half);
      end
      7: begin
        r  = a / 2;
        bf = ((a % 2) != 0);
      end
      default: r = 0;
    endcase
    nf = (r == 0);
    sf = (r >= half);
    return (20'(r) << 4) | 20'({bf, nf, of, sf});
  endfunction

  task automatic checkOutput(input string name, input int idx, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s dut%0d t=%0t got=%b want=%b", name, idx, $time, act, exp);
    end
  endtask

  task automatic checkWord(input string name, input logic [19:0] act, input logic [19:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Every cycle, 1 time unit after the rising edge, compare all instances
  always @(posedge clk) begin
    #1;
    if (checkOn) begin
      for (int i = 0; i < N_DUT; i++) begin
        checkOutput("miso", i, miso[i], expMiso[i]);
        checkOutput("busy", i, busy[i], expBusy[i]);
        checkOutput("done", i, done[i], expDone[i]);
        checkOutput("frame_err", i, ferr[i], expErr[i]);
      end
    end
  end

  // Drive one edge's inputs and record what the outputs must be after it
  task automatic applyStimulus(input int idx, input logic csV, input logic mosiV,
                               input logic eMiso, input logic eBusy, input logic eDone);
    @(negedge clk);
    cs[idx]      = csV;
    mosi[idx]    = mosiV;
    expMiso[idx] = eMiso;
    expBusy[idx] = eBusy;
    expDone[idx] = eDone;
    expErr[idx]  = errSt[idx];
  endtask

  // Assert reset between edges and confirm every output drops at once
  task automatic doReset();
    @(negedge clk);
    checkOn = 1'b0;
    #2;
    rstN = 1'b0;
    #1;
    for (int i = 0; i < N_DUT; i++) begin
      checkOutput("rst_miso", i, miso[i], 1'b0);
      checkOutput("rst_busy", i, busy[i], 1'b0);
      checkOutput("rst_done", i, done[i], 1'b0);
      checkOutput("rst_frame_err", i, ferr[i], 1'b0);
    end
    cs      = '1;
    mosi    = '0;
    errSt   = '0;
    expMiso = '0;
    expBusy = '0;
    expDone = '0;
    expErr  = '0;
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOn = 1'b1;
  endtask

  task automatic idleEdges(input int idx, input int n);
    repeat (n) applyStimulus(idx, 1'b1, 1'($urandom_range(1, 0)), 1'b0, 1'b0, 1'b0);
  endtask

  // CS kept low after a non-burst response: the slave must sit busy and silent
  task automatic holdLow(input int idx, input int n);
    repeat (n) applyStimulus(idx, 1'b0, 1'($urandom_range(1, 0)), 1'b0, 1'b1, 1'b0);
  endtask

  // One frame as an edge timeline: 3*W capture edges, RESP_W response bits, done edge.
  // abortEdge/rstEdge (0 = none) raise CS or assert reset on that edge instead.
  task automatic runFrame(input int idx, input int a, input int b, input int op,
                          input int abortEdge, input int rstEdge);
    int          w, rw, nEdge, opf;
    logic [19:0] resp;
    logic        bitV, eM, eBusy;
    w     = widthOf[idx];
    rw    = w + 4;
    nEdge = 3 * w + rw + 1;
    resp  = model(w, a, b, op);
    opf   = (op << (w - 4)) | int'($urandom_range((1 << (w - 4)) - 1, 0));
    for (int k = 1; k <= nEdge; k++) begin
      if (k == rstEdge) begin
        doReset();
        return;
      end
      if (k == abortEdge) begin
        errSt[idx] = 1'b1;
        applyStimulus(idx, 1'b1, 1'($urandom_range(1, 0)), 1'b0, 1'b0, 1'b0);
        return;
      end
      if (k <= w)          bitV = ((a >> (w - k)) & 1) != 0;
      else if (k <= 2 * w) bitV = ((b >> (2 * w - k)) & 1) != 0;
      else if (k <= 3 * w) bitV = ((opf >> (3 * w - k)) & 1) != 0;
      else                 bitV = 1'($urandom_range(1, 0));
      if (k > 3 * w && k <= 3 * w + rw) eM = resp[rw - 1 - (k - 3 * w - 1)];
      else                              eM = 1'b0;
      eBusy      = (k == nEdge) ? !burstOf[idx] : 1'b1;
      errSt[idx] = 1'b0;
      applyStimulus(idx, 1'b0, bitV, eM, eBusy, k == nEdge);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog t=%0t got=running want=finished", $time);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a, b, op, ab;
    rstN    = 1'b0;
    cs      = '1;
    mosi    = '0;
    errSt   = '0;
    expMiso = '0;
    expBusy = '0;
    expDone = '0;
    expErr  = '0;
    doReset();

    // Hand-computed response words pin the model
    checkWord("model_add_05_03", model(8, 'h05, 'h03, 0), 20'h00080);
    checkWord("model_add_7f_01", model(8, 'h7F, 'h01, 0), 20'h00803);
    checkWord("model_sub_80_01", model(8, 'h80, 'h01, 1), 20'h007F2);
    checkWord("model_sub_00_01", model(8, 'h00, 'h01, 1), 20'h00FF9);
    checkWord("model_add16",     model(16, 'h0005, 'h0003, 0), 20'h00080);

    // Basic add, overflow add, abort after 12 bits then recovery
    runFrame(0, 'h05, 'h03, 0, 0, 0);
    idleEdges(0, 2);
    runFrame(0, 'h7F, 'h01, 0, 0, 0);
    idleEdges(0, 2);
    runFrame(0, 'hA5, 'h3C, 1, 13, 0);
    idleEdges(0, 3);
    runFrame(0, 'h10, 'h20, 1, 0, 0);
    idleEdges(0, 2);

    // CS held low after the response
    runFrame(0, 'h33, 'h0F, 4, 0, 0);
    holdLow(0, 6);
    idleEdges(0, 2);

    // Random traffic with occasional aborts, including on the done edge
    for (int n = 0; n < 25; n++) begin
      a  = $urandom_range(255, 0);
      b  = $urandom_range(255, 0);
      op = $urandom_range(15, 0);
      ab = ($urandom_range(4, 0) == 0) ? $urandom_range(37, 2) : 0;
      if (n == 5) ab = 37;
      runFrame(0, a, b, op, ab, 0);
      idleEdges(0, $urandom_range(2, 1));
    end

    // Back-to-back burst frames with CS held low
    for (int n = 0; n < 4; n++) begin
      runFrame(1, (n == 0) ? 'h05 : int'($urandom_range(255, 0)),
               (n == 0) ? 'h03 : int'($urandom_range(255, 0)),
               (n == 0) ? 0 : int'($urandom_range(7, 0)), 0, 0);
    end
    idleEdges(1, 2);
    runFrame(1, 'h44, 'h22, 1, 20, 0);
    runFrame(1, 'h44, 'h22, 1, 0, 0);
    runFrame(1, 'hFF, 'h01, 0, 0, 0);
    idleEdges(1, 2);

    // Reset in the middle of the response
    runFrame(0, 'hC3, 'h5A, 2, 0, 30);
    runFrame(0, 'h05, 'h03, 0, 0, 0);
    idleEdges(0, 2);

    // 16-bit regression, reset during the response, then random traffic
    runFrame(2, 'h0005, 'h0003, 0, 0, 0);
    idleEdges(2, 2);
    runFrame(2, 'h7FFF, 'h0001, 0, 0, 3 * 16 + 6);
    runFrame(2, 'h0005, 'h0003, 0, 0, 0);
    idleEdges(2, 2);
    for (int n = 0; n < 10; n++) begin
      ab = ($urandom_range(4, 0) == 0) ? $urandom_range(69, 2) : 0;
      runFrame(2, $urandom_range(65535, 0), $urandom_range(65535, 0),
               $urandom_range(15, 0), ab, 0);
      idleEdges(2, 2);
    end

    @(negedge clk);
    checkOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
